add_sub_seq: RTL and testbench



---
 rtl/add_sub_seq.sv | 180 ++++++++++++++++++
 tb/tb_add_sub_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// Request sequencer in front of an external 4-bit adder-subtractor: registers the operands
// onto its pins, captures its result one cycle later, and holds it on a valid/ready output.
//
// state    | meaning
// ST_IDLE  | waiting for a request; in_ready high
// ST_DRIVE | operands on a*/b*/cin, adder settling
// ST_HOLD  | result registered; out_valid high until out_ready
module add_sub_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_sub,
    input  logic       in_acc,
    input  logic       acc_clr,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       b0,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       cin,
    input  logic       sum0,
    input  logic       sum1,
    input  logic       sum2,
    input  logic       sum3,
    input  logic       cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_cout,
    output logic       out_zero,
    output logic       out_borrow,
    output logic       out_ovf,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] opb_q, opb_d;
    logic       cin_q, cin_d;
    logic [3:0] sum_q, sum_d;
    logic       cout_q, cout_d;
    logic       zero_q, zero_d;
    logic       borrow_q, borrow_d;
    logic       ovf_q, ovf_d;
    logic [3:0] acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;

    logic       accept;
    logic       capture;
    logic [3:0] sum_in;
    logic       ovf_calc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            ST_DRIVE: capture   = 1'b1;
            ST_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign sum_in = {sum3, sum2, sum1, sum0};

    // Overflow is judged against the registered drive bits, not the request inputs.
    always_comb begin
        if (cin_q) begin
            ovf_calc = (opa_q[3] != opb_q[3]) && (sum3 != opa_q[3]);
        end else begin
            ovf_calc = (opa_q[3] == opb_q[3]) && (sum3 != opa_q[3]);
        end
    end

    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        cin_d    = cin_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept) begin
            opa_d = in_acc ? acc_q : in_a;
            opb_d = in_b;
            cin_d = in_sub;
        end
        if (capture) begin
            sum_d    = sum_in;
            cout_d   = cout;
            zero_d   = (sum_in == 4'd0);
            borrow_d = cin_q & ~cout;
            ovf_d    = ovf_calc;
            acc_d    = sum_in;
            cnt_d    = cnt_q + 8'd1;
        end
        // Clear wins over the capture update; an accept in the same cycle already saw the old acc.
        if (acc_clr) begin
            acc_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q    <= 4'd0;
            opb_q    <= 4'd0;
            cin_q    <= 1'b0;
            sum_q    <= 4'd0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= 4'd0;
            cnt_q    <= 8'd0;
        end else begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign {a3, a2, a1, a0} = opa_q;
    assign {b3, b2, b1, b0} = opb_q;
    assign cin        = cin_q;
    assign out_sum    = sum_q;
    assign out_cout   = cout_q;
    assign out_zero   = zero_q;
    assign out_borrow = borrow_q;
    assign out_ovf    = ovf_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: behavioural adder-subtractor on the pins, directed plan cases,
// then randomized ops checked against an arithmetic reference model.
module tb_add_sub_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = 4'd0;
    logic [3:0] in_b = 4'd0;
    logic       in_sub = 1'b0;
    logic       in_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       a0, a1, a2, a3, b0, b1, b2, b3, cin;
    logic       sum0, sum1, sum2, sum3, cout;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_sum;
    logic       out_cout, out_zero, out_borrow, out_ovf;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_pass = 0;

    logic [3:0] acc_m = 4'd0;
    logic [7:0] cnt_m = 8'd0;

    wire [3:0] a_pins = {a3, a2, a1, a0};
    wire [3:0] b_pins = {b3, b2, b1, b0};

    always #5 clk = ~clk;

    // External adder-subtractor: sub computes A + ~B + 1
    logic [4:0] adder_res;
    always_comb begin
        adder_res = {1'b0, a_pins} + {1'b0, (cin ? ~b_pins : b_pins)} + {4'd0, cin};
    end
    assign {cout, sum3, sum2, sum1, sum0} = adder_res;

    add_sub_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc), .acc_clr(acc_clr),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .cin(cin),
        .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
        .out_borrow(out_borrow), .out_ovf(out_ovf), .op_count(op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int s4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_a_pins"}, a_pins, 0);
        check({tag, "_b_pins"}, b_pins, 0);
        check({tag, "_cin"}, cin, 0);
        check({tag, "_payload"}, {out_sum, out_cout, out_zero, out_borrow, out_ovf}, 0);
        check({tag, "_op_count"}, op_count, 0);
    endtask

    // clr_mode: 0 none, 1 acc_clr in the accept cycle, 2 acc_clr in the DRIVE cycle
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                          input logic acc, input int bp, input int clr_mode);
        logic [3:0] ea, es;
        logic       ec, ez, eb, eo;
        int         r, w;
        logic [7:0] snap;
        ea = acc ? acc_m : a;
        if (sub) begin
            es = 4'((int'(ea) - int'(b)) & 15);
            ec = (ea >= b);
            r  = s4(ea) - s4(b);
        end else begin
            es = 4'((int'(ea) + int'(b)) & 15);
            ec = (int'(ea) + int'(b)) > 15;
            r  = s4(ea) + s4(b);
        end
        ez = (es == 4'd0);
        eb = sub & ~ec;
        eo = (r > 7) || (r < -8);

        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("ready_timeout", 0, 1);

        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_acc = acc;
        acc_clr  = (clr_mode == 1);
        @(negedge clk);
        in_valid = 1'b0; in_a = 4'($urandom); in_b = 4'($urandom);
        in_sub = 1'($urandom); in_acc = 1'($urandom);
        acc_clr  = (clr_mode == 2);
        check("drv_a_pins", a_pins, ea);
        check("drv_b_pins", b_pins, b);
        check("drv_cin", cin, sub);
        check("drv_in_ready", in_ready, 0);
        check("drv_out_valid", out_valid, 0);
        @(negedge clk);
        acc_clr = 1'b0;
        cnt_m = cnt_m + 8'd1;
        acc_m = (clr_mode == 2) ? 4'd0 : es;
        check("res_out_valid", out_valid, 1);
        check("res_in_ready", in_ready, 0);
        check("res_sum", out_sum, es);
        check("res_cout", out_cout, ec);
        check("res_zero", out_zero, ez);
        check("res_borrow", out_borrow, eb);
        check("res_ovf", out_ovf, eo);
        check("res_op_count", op_count, cnt_m);
        snap = {out_sum, out_cout, out_zero, out_borrow, out_ovf};
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1; in_a = 4'($urandom); in_b = 4'($urandom);
            @(negedge clk);
            check("bp_payload", {out_sum, out_cout, out_zero, out_borrow, out_ovf}, snap);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_a_pins", a_pins, ea);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("done_in_ready", in_ready, 1);
        check("done_out_valid", out_valid, 0);
    endtask

    initial begin
        #12;
        check_idle_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b1010, 4'b1010, 1'b0, 1'b0, 0, 0);
        run_op(4'b1010, 4'b1010, 1'b1, 1'b0, 0, 0);
        run_op(4'b0110, 4'b0011, 1'b0, 1'b0, 0, 0);
        run_op(4'b0110, 4'b0011, 1'b1, 1'b0, 0, 0);
        run_op(4'b0011, 4'b0110, 1'b1, 1'b0, 0, 0);

        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        acc_m = 4'd0;
        run_op(4'b1111, 4'b0101, 1'b0, 1'b1, 0, 0);
        run_op(4'b1111, 4'b0101, 1'b0, 1'b1, 0, 0);
        run_op(4'b1111, 4'b0011, 1'b1, 1'b1, 0, 0);
        check("chain_acc", acc_m, 4'b0111);

        run_op(4'b0101, 4'b0100, 1'b0, 1'b0, 5, 0);

        run_op(4'b0000, 4'b0001, 1'b0, 1'b1, 0, 1);
        run_op(4'b0000, 4'b0010, 1'b0, 1'b1, 0, 2);
        run_op(4'b0000, 4'b0011, 1'b0, 1'b1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Reset while in DRIVE: discard the op
        in_valid = 1'b1; in_a = 4'b1111; in_b = 4'b1111; in_sub = 1'b0; in_acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_drive_a", a_pins, 4'b1111);
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_drive");
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("post_rst");
        cnt_m = 8'd0;
        acc_m = 4'd0;

        for (int i = 0; i < 256; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 0, 0);
        end
        check("wrap_op_count", op_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
